// File: rtl/mem_req_stage.sv
// Data-memory request stage: turns an executed load/store into one dmem
// req/gnt/rvalid transaction and holds the returned load data for mem_slice_stage.
module mem_req_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    input  logic        squash_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        busy_oa,
    output logic        misalign_oa
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    state_t      state;
    state_t      state_next;

    logic        mem_op;
    logic        width_bad;
    logic        access;
    logic        we_next;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        kill;
    logic [31:0] rdata_q;

    // Alignment check; width 3 is an illegal encoding and counts as misaligned.
    always_comb begin
        mem_op    = valid_i & (mem_read_i | mem_write_i);
        width_bad = 1'b0;
        case (mem_width_i)
            WIDTH_BYTE: width_bad = 1'b0;
            WIDTH_HALF: width_bad = addr_i[0];
            WIDTH_WORD: width_bad = |addr_i[1:0];
            default:    width_bad = 1'b1;
        endcase
        misalign_oa = mem_op & width_bad;
        access      = mem_op & ~width_bad & ~squash_i;
        we_next     = mem_write_i & ~mem_read_i;
    end

    always_comb begin
        be_next    = 4'b0000;
        wdata_next = 32'h0;
        case (mem_width_i)
            WIDTH_BYTE: begin
                be_next    = 4'b0001 << addr_i[1:0];
                wdata_next = {4{wdata_i[7:0]}};
            end
            WIDTH_HALF: begin
                be_next    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_next = {2{wdata_i[15:0]}};
            end
            WIDTH_WORD: begin
                be_next    = 4'b1111;
                wdata_next = wdata_i;
            end
            default: begin
                be_next    = 4'b0000;
                wdata_next = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access)        state_next = REQ;
            REQ:  if (dmem_gnt_i)    state_next = req_we ? DONE : RESP;
            RESP: if (dmem_rvalid_i) state_next = DONE;
            DONE: if (!stall_i)      state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o = (state == REQ);
        busy_oa    = ((state == IDLE) & access) | (state == REQ) | (state == RESP);
    end

    // Request fields are captured once on accept so they stay frozen while req is up.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_we    <= 1'b0;
            req_addr  <= 32'h0;
            req_be    <= 4'b0000;
            req_wdata <= 32'h0;
        end else if ((state == IDLE) && access) begin
            req_we    <= we_next;
            req_addr  <= {addr_i[31:2], 2'b00};
            req_be    <= be_next;
            req_wdata <= wdata_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            kill <= 1'b0;
        end else if ((state == DONE) && !stall_i) begin
            kill <= 1'b0;
        end else if (((state == REQ) || (state == RESP)) && squash_i) begin
            kill <= 1'b1;
        end
    end

    // A squash arriving in the same cycle as rvalid also blocks the capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= 32'h0;
        end else if ((state == RESP) && dmem_rvalid_i && !kill && !squash_i) begin
            rdata_q <= dmem_rdata_i;
        end
    end

    assign dmem_we_o    = req_we;
    assign dmem_addr_o  = req_addr;
    assign dmem_be_o    = req_be;
    assign dmem_wdata_o = req_wdata;
    assign rdata_o      = rdata_q;

endmodule

// File: doc/mem_req_stage.md
# mem_req_stage

Data-memory request stage between Execute and `mem_slice_stage`. Turns the executed load/store into a single dmem transaction: word-aligned address, byte enables, lane-replicated store data, and a req/gnt/rvalid handshake. It captures load data into a holding register that drives the `dmem_rdata_i` input of `mem_slice_stage`. It also raises a stall while the access is in flight and flags misaligned accesses.

## Interface
Parameters: none.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; synchronous and active-low. Sampled at `posedge clk_i`.
- `valid_i`  in  1  Execute-stage instruction valid
- `mem_read_i`  in  1  load
- `mem_write_i`  in  1  store
- `mem_width_i`  in  2  BYTE=0, HALF=1, WORD=2; 3 is illegal
- `addr_i`  in  32  effective address (`alu_out`)
- `wdata_i`  in  32  store data (`rs2_data`)
- `stall_i`  in  1  stage stall from hazard unit (`stage_ctrl_t.stall`)
- `squash_i`  in  1  stage squash (`stage_ctrl_t.squash`)
- `dmem_req_o`  out  1  request valid
- `dmem_we_o`  out  1  1 = write
- `dmem_addr_o`  out  32  word-aligned address
- `dmem_be_o`  out  4  byte enables
- `dmem_wdata_o`  out  32  lane-replicated store data
- `dmem_gnt_i`  in  1  request accepted
- `dmem_rvalid_i`  in  1  read data valid
- `dmem_rdata_i`  in  32  read data
- `rdata_o`  out  32  captured load data, fed to `mem_slice_stage`
- `busy_oa`  out  1  combinational stall request to hazard unit
- `misalign_oa`  out  1  combinational misaligned-access flag

## Operation
- `access` = `valid_i & (mem_read_i | mem_write_i) & ~misalign_oa & ~squash_i`. When both read and write are set, it is treated as a read.
- `misalign_oa` = `valid_i & (mem_read_i | mem_write_i)` & (HALF & `addr_i[0]` | WORD & `addr_i[1:0]`≠0 | width=3). A misaligned access never issues a request.
- States:
  - IDLE: `access` → REQ. Latch `we`, `addr`, `be`, and `wdata` into request registers.
  - REQ: `dmem_req_o`=1. On `dmem_gnt_i`: a read goes to RESP, a write goes to DONE.
  - RESP: on `dmem_rvalid_i`, load `rdata_o` ← `dmem_rdata_i` unless the access is killed; go to DONE.
  - DONE: `!stall_i` → IDLE; otherwise hold.
- `busy_oa` = (IDLE & `access`) | REQ | RESP.
- Byte enables, with `off` = `addr_i[1:0]`:
  - BYTE: `4'b0001 << off`
  - HALF: `4'b0011 << (2*off[1])`
  - WORD: `4'b1111`
- Store data:
  - BYTE: `{4{wdata_i[7:0]}}`
  - HALF: `{2{wdata_i[15:0]}}`
  - WORD: `wdata_i`
- `dmem_addr_o` = `{addr[31:2],2'b00}`.
- Request outputs are driven from registers and stay stable from the first REQ cycle until the cycle `gnt` is seen. They never change while `dmem_req_o`=1.
- Squash:
  - In IDLE, squash suppresses the request.
  - In REQ or RESP, squash sets a sticky `kill` bit. The handshake still completes (a request is never retracted), but `rdata_o` is not updated. `kill` clears on the DONE→IDLE transition.
- `rdata_o` holds its value except on a non-killed RESP capture.
- `dmem_rvalid_i` is ignored outside RESP.
- `dmem_gnt_i` is ignored outside REQ.

## Timing
- Reset values: state=IDLE, `dmem_req_o`=0, `dmem_we_o`=0, `dmem_addr_o`=0, `dmem_be_o`=0, `dmem_wdata_o`=0, `rdata_o`=0, `kill`=0.
- Reset mid-transaction (REQ or RESP): on the next edge, `dmem_req_o` drops and state returns to IDLE. A late `rvalid` is ignored.
- Accept edge at cycle T. `dmem_req_o`=1 from T+1.
- Zero-wait memory (gnt in T+1, rvalid in T+2):
  - `rdata_o` is valid from T+3.
  - `busy_oa` is high in T, T+1, and T+2, and low in T+3 (DONE).
- Write with gnt in T+1: DONE in T+2.
- While `stall_i` is held in DONE, state is held and nothing is reissued. The first `!stall_i` edge returns to IDLE; the next instruction is seen the following cycle.
- If `gnt` and `rvalid` both arrive in the same REQ cycle, only `gnt` is honoured. `rvalid` must arrive at least one cycle after `gnt`.
- `busy_oa` and `misalign_oa` are purely combinational, with no registered path.

## Test plan
- LW at address 0x104, gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF.
  - Required: `dmem_addr_o`=0x104, `be`=4'hF, `we`=0, req held stable for 3 cycles.
  - `rdata_o`=0xDEADBEEF the cycle after rvalid; `busy_oa` drops that same cycle.
- SB with `wdata_i`=0x000000A5 at 0x203, immediate gnt.
  - Required: `dmem_addr_o`=0x200, `be`=4'b1000, `wdata`=0xA5A5A5A5, `we`=1; DONE two cycles after accept.
- SH at 0x101 → `misalign_oa`=1, `dmem_req_o` stays 0, `busy_oa`=0.
- LW with `squash_i` pulsed while in REQ.
  - Required: req stays high until gnt; after rvalid, `rdata_o` keeps its previous value; FSM reaches IDLE.
- `stall_i`=1 for 4 cycles in DONE after an SW.
  - Required: exactly one gnt-acknowledged request; `dmem_req_o`=0 throughout DONE.
- `rst_ni`=0 asserted while in RESP, then rvalid arrives.
  - Required: every output at its reset value, `rdata_o`=0, rvalid ignored.
